// File: rtl/cmd_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cmd_bus_arbiter
// Purpose  : Round-robin arbiter sharing one command-bus master port among
//            P_NUM_REQ requesters. One pending slot per requester, one
//            transaction in flight, ack/rdata or timeout routed to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_bus_arbiter #(
  parameter int P_NUM_REQ       = 4,
  parameter int ADDR_BITS       = 24,
  parameter int DATA_BITS       = 32,
  parameter int P_WATCHDOG_CLKS = 64
) (
  input  logic                           i_sysclk,
  input  logic                           i_srst,
  input  logic [P_NUM_REQ-1:0]           i_req_sel,
  input  logic [P_NUM_REQ-1:0]           i_req_rd_wr_n,
  input  logic [P_NUM_REQ*ADDR_BITS-1:0] i_req_byte_addr,
  input  logic [P_NUM_REQ*DATA_BITS-1:0] i_req_wdata,
  output logic [P_NUM_REQ-1:0]           o_req_ack,
  output logic [P_NUM_REQ-1:0]           o_req_timeout,
  output logic [DATA_BITS-1:0]           o_req_rdata,
  output logic [P_NUM_REQ-1:0]           o_req_overflow,
  output logic                           o_m_sel,
  output logic                           o_m_rd_wr_n,
  output logic [ADDR_BITS-1:0]           o_m_byte_addr,
  output logic [DATA_BITS-1:0]           o_m_wdata,
  input  logic                           i_m_ack,
  input  logic [DATA_BITS-1:0]           i_m_rdata,
  input  logic                           i_m_timeout,
  output logic                           o_busy,
  output logic [$clog2(P_NUM_REQ)-1:0]   o_grant_idx
);

  localparam int IDX_W = $clog2(P_NUM_REQ);
  localparam int WD_W  = $clog2(P_WATCHDOG_CLKS);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(P_NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(P_WATCHDOG_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [P_NUM_REQ-1:0]   pending_q, pending_d;
  logic [P_NUM_REQ-1:0]   slot_rw_q, slot_rw_d;
  logic [ADDR_BITS-1:0]   slot_addr_q  [P_NUM_REQ];
  logic [ADDR_BITS-1:0]   slot_addr_d  [P_NUM_REQ];
  logic [DATA_BITS-1:0]   slot_wdata_q [P_NUM_REQ];
  logic [DATA_BITS-1:0]   slot_wdata_d [P_NUM_REQ];
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   m_sel_q, m_sel_d;
  logic                   m_rw_q, m_rw_d;
  logic [ADDR_BITS-1:0]   m_addr_q, m_addr_d;
  logic [DATA_BITS-1:0]   m_wdata_q, m_wdata_d;
  logic [P_NUM_REQ-1:0]   ack_q, ack_d;
  logic [P_NUM_REQ-1:0]   tmo_q, tmo_d;
  logic [P_NUM_REQ-1:0]   ovf_q, ovf_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;

  logic                   hi_found, lo_found, pick_found;
  logic [IDX_W-1:0]       hi_idx, lo_idx, pick_idx;

  // Round-robin pick: lowest pending index above the pointer, else wrap to lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        if (i > int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Slot capture plus IDLE/ISSUE/WAIT sequencing; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    slot_rw_d    = slot_rw_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    wd_d         = wd_q;
    m_sel_d      = 1'b0;
    m_rw_d       = m_rw_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    ack_d        = '0;
    tmo_d        = '0;
    ovf_d        = '0;
    rdata_d      = '0;

    // A slot that is still pending (including its own completion cycle) rejects new requests.
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (i_req_sel[k]) begin
        if (pending_q[k]) begin
          ovf_d[k] = 1'b1;
        end else begin
          pending_d[k]    = 1'b1;
          slot_rw_d[k]    = i_req_rd_wr_n[k];
          slot_addr_d[k]  = i_req_byte_addr[k*ADDR_BITS +: ADDR_BITS];
          slot_wdata_d[k] = i_req_wdata[k*DATA_BITS +: DATA_BITS];
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          rr_ptr_d  = pick_idx;
          m_sel_d   = 1'b1;
          m_rw_d    = slot_rw_q[pick_idx];
          m_addr_d  = slot_addr_q[pick_idx];
          m_wdata_d = slot_wdata_q[pick_idx];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ack has priority over a simultaneous timeout.
        if (i_m_ack) begin
          ack_d[grant_q]     = 1'b1;
          rdata_d            = i_m_rdata;
          pending_d[grant_q] = 1'b0;
          state_d            = ST_IDLE;
        end else if (i_m_timeout || (wd_q == WD_LAST)) begin
          tmo_d[grant_q]     = 1'b1;
          pending_d[grant_q] = 1'b0;
          state_d            = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction without a completion pulse.
  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      slot_rw_q <= '0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
        slot_addr_q[k]  <= '0;
        slot_wdata_q[k] <= '0;
      end
      grant_q   <= '0;
      rr_ptr_q  <= RR_RESET;
      wd_q      <= '0;
      m_sel_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      ack_q     <= '0;
      tmo_q     <= '0;
      ovf_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      slot_rw_q    <= slot_rw_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      wd_q         <= wd_d;
      m_sel_q      <= m_sel_d;
      m_rw_q       <= m_rw_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      ack_q        <= ack_d;
      tmo_q        <= tmo_d;
      ovf_q        <= ovf_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_req_ack      = ack_q;
  assign o_req_timeout  = tmo_q;
  assign o_req_rdata    = rdata_q;
  assign o_req_overflow = ovf_q;
  assign o_m_sel        = m_sel_q;
  assign o_m_rd_wr_n    = m_rw_q;
  assign o_m_byte_addr  = m_addr_q;
  assign o_m_wdata      = m_wdata_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_grant_idx    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmd_bus_arbiter
// Purpose  : Self-checking bench for cmd_bus_arbiter: cycle vector table for
//            single/read/fairness traffic, hand sequences for overflow,
//            timeouts, watchdog and mid-transaction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int WD = 64;

  logic            clk = 1'b0;
  logic            srst;
  logic [N-1:0]    req_sel, req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ack, req_tmo, req_ovf;
  logic [DW-1:0]   req_rdata;
  logic            m_sel, m_rw;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ack, m_tmo;
  logic [DW-1:0]   m_rdata;
  logic            busy;
  logic [1:0]      gnt;

  always #5 clk = ~clk;

  cmd_bus_arbiter #(
    .P_NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW), .P_WATCHDOG_CLKS(WD)
  ) dut (
    .i_sysclk(clk), .i_srst(srst),
    .i_req_sel(req_sel), .i_req_rd_wr_n(req_rw),
    .i_req_byte_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ack(req_ack), .o_req_timeout(req_tmo),
    .o_req_rdata(req_rdata), .o_req_overflow(req_ovf),
    .o_m_sel(m_sel), .o_m_rd_wr_n(m_rw), .o_m_byte_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_ack(m_ack), .i_m_rdata(m_rdata), .i_m_timeout(m_tmo),
    .o_busy(busy), .o_grant_idx(gnt)
  );

  // Per-requester request contents (req2 is the reader).
  logic [AW-1:0] addr_c [N];
  logic [DW-1:0] wd_c   [N];
  logic [N-1:0]  rw_c;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: pulse counts and cycle stamps, sampled mid-cycle.
  int            cyc = 0;
  int            msel_cnt = 0;
  int            msel_cyc = 0;
  int            tmo_cyc = 0;
  logic [AW-1:0] ms_addr;
  logic [DW-1:0] ms_wdata;
  logic [1:0]    ms_gnt;
  int            ack_cnt [N];
  int            tmo_cnt [N];
  int            ovf_cnt [N];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_sel) begin
      msel_cnt <= msel_cnt + 1;
      msel_cyc <= cyc;
      ms_addr  <= m_addr;
      ms_wdata <= m_wdata;
      ms_gnt   <= gnt;
    end
    if (req_tmo != '0) tmo_cyc <= cyc;
    for (int k = 0; k < N; k++) begin
      if (req_ack[k]) ack_cnt[k] <= ack_cnt[k] + 1;
      if (req_tmo[k]) tmo_cnt[k] <= tmo_cnt[k] + 1;
      if (req_ovf[k]) ovf_cnt[k] <= ovf_cnt[k] + 1;
    end
  end

  task automatic wait_msel(input int prev, input string name);
    int k;
    k = 0;
    while (msel_cnt == prev && k < 20) begin
      step();
      k++;
    end
    chk(name, 64'(msel_cnt != prev), 64'd1);
  endtask

  typedef struct {
    int          n;
    logic [N-1:0] sel;
    logic        ack;
    logic        tmo;
    logic [DW-1:0] mrd;
    logic        e_msel;
    logic        e_busy;
    logic [1:0]  e_gnt;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_tmo;
    logic [N-1:0] e_ovf;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t V(input int n, input logic [N-1:0] sel, input logic ack,
                             input logic tmo, input logic [DW-1:0] mrd, input logic e_msel,
                             input logic e_busy, input logic [1:0] e_gnt, input logic [N-1:0] e_ack,
                             input logic [N-1:0] e_tmo, input logic [N-1:0] e_ovf,
                             input logic [DW-1:0] e_rd);
    vec_t v;
    v.n = n; v.sel = sel; v.ack = ack; v.tmo = tmo; v.mrd = mrd;
    v.e_msel = e_msel; v.e_busy = e_busy; v.e_gnt = e_gnt;
    v.e_ack = e_ack; v.e_tmo = e_tmo; v.e_ovf = e_ovf; v.e_rd = e_rd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ms0, ms1, p, icyc;
    int o0, a0;
    logic [DW-1:0] rd;

    addr_c[0] = 24'h000004; wd_c[0] = 32'h01010202;
    addr_c[1] = 24'h100010; wd_c[1] = 32'h11111111;
    addr_c[2] = 24'h000008; wd_c[2] = 32'h22222222;
    addr_c[3] = 24'h300030; wd_c[3] = 32'h33333333;
    rw_c = 4'b0100;
    req_rw = rw_c;
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = addr_c[k];
      req_wdata[k*DW +: DW] = wd_c[k];
    end
    srst = 1'b1; req_sel = '0; m_ack = 1'b0; m_tmo = 1'b0; m_rdata = '0;

    // ---- Vector table ----
    // Fairness straight out of reset: grants 0,1,2,3 then 0,1,2,3 again.
    vq.push_back(V(1, 4'b1111, 0, 0, '0, 0, 0, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 0, 0, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int g = 0; g < 4; g++) begin
        rd = 32'hD00D0000 + 32'(g);
        vq.push_back(V(1, 4'b0, 0, 0, '0, 1, 1, 2'(g), 4'b0, 4'b0, 4'b0, '0));
        vq.push_back(V(1, 4'b0, 1, 0, rd, 0, 1, 2'(g), 4'b0, 4'b0, 4'b0, '0));
        vq.push_back(V(1, (rnd == 0) ? 4'(1 << g) : 4'b0, 0, 0, '0, 0, 0, 2'(g),
                       4'(1 << g), 4'b0, 4'b0, rd));
      end
    end
    vq.push_back(V(2, 4'b0, 0, 0, '0, 0, 0, 2'd3, 4'b0, 4'b0, 4'b0, '0));
    // Single write from req0, master acks ten clocks after the request.
    vq.push_back(V(1, 4'b0001, 0, 0, '0, 0, 0, 2'd3, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 0, 0, 2'd3, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 1, 1, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(9, 4'b0000, 0, 0, '0, 0, 1, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 1, 0, '0, 0, 1, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 0, 0, 2'd0, 4'b0001, 4'b0, 4'b0, '0));
    vq.push_back(V(2, 4'b0000, 0, 0, '0, 0, 0, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    // Read from req2 returning 0xCAFEF00D.
    vq.push_back(V(1, 4'b0100, 0, 0, '0, 0, 0, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 0, 0, 2'd0, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 1, 1, 2'd2, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(3, 4'b0000, 0, 0, '0, 0, 1, 2'd2, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 1, 0, 32'hCAFEF00D, 0, 1, 2'd2, 4'b0, 4'b0, 4'b0, '0));
    vq.push_back(V(1, 4'b0000, 0, 0, '0, 0, 0, 2'd2, 4'b0100, 4'b0, 4'b0, 32'hCAFEF00D));
    vq.push_back(V(2, 4'b0000, 0, 0, '0, 0, 0, 2'd2, 4'b0, 4'b0, 4'b0, '0));

    // ---- Reset state ----
    step(); step();
    chk("reset_ctrl", {m_sel, busy, gnt, req_ack, req_tmo, req_ovf, req_rdata}, 64'd0);
    chk("reset_mport", {m_rw, m_addr, m_wdata}, 64'd0);
    step();
    srst = 1'b0;

    // ---- Apply vector table ----
    for (int i = 0; i < vq.size(); i++) begin
      for (int r = 0; r < vq[i].n; r++) begin
        step();
        chk($sformatf("vec%0d.%0d", i, r),
            {m_sel, busy, gnt, req_ack, req_tmo, req_ovf, req_rdata},
            {vq[i].e_msel, vq[i].e_busy, vq[i].e_gnt, vq[i].e_ack, vq[i].e_tmo,
             vq[i].e_ovf, vq[i].e_rd});
        if (vq[i].e_msel)
          chk($sformatf("vec%0d.mport", i), {m_rw, m_addr, m_wdata},
              {rw_c[vq[i].e_gnt], addr_c[vq[i].e_gnt], wd_c[vq[i].e_gnt]});
        req_sel = vq[i].sel;
        m_ack   = vq[i].ack;
        m_tmo   = vq[i].tmo;
        m_rdata = vq[i].mrd;
      end
    end

    // ---- Overflow: req1 re-posts while its slot waits behind req0 ----
    ms0 = msel_cnt; o0 = ovf_cnt[1];
    req_sel = 4'b0011;
    step(); req_sel = 4'b0000;
    step();
    step();
    req_addr[1*AW +: AW]  = 24'h1ABCDE;
    req_wdata[1*DW +: DW] = 32'hDEADBEEF;
    req_sel = 4'b0010;
    step();
    chk("ovf_pulse", 64'(req_ovf), 64'h2);
    req_sel = 4'b0000; m_ack = 1'b1; m_rdata = 32'h0;
    step();
    chk("ovf_req0_ack", 64'(req_ack), 64'h1);
    m_ack = 1'b0;
    wait_msel(ms0 + 1, "ovf_req1_issue");
    chk("ovf_req1_content", {ms_gnt, ms_addr, ms_wdata}, {2'd1, 24'h100010, 32'h11111111});
    step();
    // Sel in the owner's own completion cycle is still an overflow.
    m_ack = 1'b1; m_rdata = 32'h12345678; req_sel = 4'b0010;
    step();
    chk("ovf_ack_cycle", {req_ack, req_ovf, req_rdata}, {4'b0010, 4'b0010, 32'h12345678});
    m_ack = 1'b0; req_sel = 4'b0000; m_rdata = '0;
    repeat (4) step();
    chk("ovf_txn_count", 64'(msel_cnt - ms0), 64'd2);
    chk("ovf_pulse_count", 64'(ovf_cnt[1] - o0), 64'd2);
    chk("ovf_idle", 64'(busy), 64'd0);

    // ---- Master timeout pulse on req3 ----
    ms0 = msel_cnt; a0 = ack_cnt[3];
    req_sel = 4'b1000;
    step(); req_sel = 4'b0000;
    wait_msel(ms0, "tmo_issue");
    step(); step();
    m_tmo = 1'b1; m_rdata = 32'hFFFFFFFF;
    step();
    chk("tmo_pulse", {req_tmo, req_ack, req_rdata}, {4'b1000, 4'b0000, 32'h0});
    m_tmo = 1'b0; m_rdata = '0;
    step();
    chk("tmo_no_ack", 64'(ack_cnt[3] - a0), 64'd0);

    // ---- Watchdog with a silent master, then the next pending slot ----
    ms0 = msel_cnt;
    req_sel = 4'b0011;
    step(); req_sel = 4'b0000;
    wait_msel(ms0, "wdog_issue");
    chk("wdog_grant", 64'(ms_gnt), 64'd0);
    icyc = msel_cyc; ms1 = msel_cnt; p = tmo_cnt[0]; a0 = ack_cnt[0];
    for (int k = 0; k < 200 && tmo_cnt[0] == p; k++) step();
    chk("wdog_fired", 64'(tmo_cnt[0] - p), 64'd1);
    // The ISSUE cycle is followed by WD wait cycles; the pulse comes in the next one.
    chk("wdog_latency", 64'(tmo_cyc - icyc), 64'(WD + 1));
    chk("wdog_no_ack", 64'(ack_cnt[0] - a0), 64'd0);
    wait_msel(ms1, "wdog_next_issue");
    chk("wdog_next_grant", 64'(ms_gnt), 64'd1);
    step();
    // Ack and timeout together: ack wins.
    m_ack = 1'b1; m_tmo = 1'b1; m_rdata = 32'h5A5A5A5A;
    step();
    chk("ack_beats_tmo", {req_ack, req_tmo, req_rdata}, {4'b0010, 4'b0000, 32'h5A5A5A5A});
    m_ack = 1'b0; m_tmo = 1'b0; m_rdata = '0;
    step();

    // ---- Reset mid-WAIT, stale ack afterwards, RR restarts at req0 ----
    ms0 = msel_cnt; a0 = ack_cnt[2];
    req_sel = 4'b0100;
    step(); req_sel = 4'b0000;
    wait_msel(ms0, "rst_issue");
    step(); step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("rst_mid_ctrl", {m_sel, busy, gnt, req_ack, req_tmo, req_ovf, req_rdata}, 64'd0);
    chk("rst_mid_mport", {m_rw, m_addr, m_wdata}, 64'd0);
    m_ack = 1'b1; m_rdata = 32'h77777777;
    step();
    m_ack = 1'b0; m_rdata = '0;
    chk("rst_stale_ack", {req_ack, req_rdata, busy}, 64'd0);
    repeat (3) step();
    chk("rst_no_ack_count", 64'(ack_cnt[2] - a0), 64'd0);
    ms0 = msel_cnt;
    req_sel = 4'b1001;
    step(); req_sel = 4'b0000;
    wait_msel(ms0, "rst_rr_issue");
    chk("rst_rr_grant", 64'(ms_gnt), 64'd0);
    step();
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk("rst_rr_ack0", 64'(req_ack), 64'h1);
    wait_msel(ms0 + 1, "rst_rr_issue2");
    chk("rst_rr_grant2", 64'(ms_gnt), 64'd3);
    step();
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    chk("rst_rr_ack3", 64'(req_ack), 64'h8);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
